serial_adder: RTL

Bit-serial binary adder. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds them LSB-first through a single 1-bit full-adder cell, one bit per clock. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequential stage that consumes the single-bit gate cells (impl, and/xor family) and produces results for the downstream result checker/display.

---
 rtl/add_pkg.sv | 15 +
 rtl/serial_adder_if.sv | 25 ++
 rtl/full_adder.sv | 18 +
 rtl/serial_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and sizing helpers for the adder family.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  // Bit counter needs at least one bit even when width is 1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder built from and/xor/or gate cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = ci & ab_x;
  assign s    = ab_x ^ ci;
  assign co   = ab_a | cx_a;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are added LSB-first through one full-adder cell, one bit per clock.
module serial_adder
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int unsigned CntW = cnt_width(WIDTH);

  serial_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             accept;
  logic             last;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   acc_cat;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept = bus.in_valid && in_ready;
  assign last   = (cnt_q == CntW'(WIDTH - 1));

  // Shift the new sum bit in at the MSB; the concat form also covers WIDTH == 1.
  assign acc_cat   = {fa_s, acc_q} >> 1;
  assign acc_shift = acc_cat[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CntW'(1);
        // Result registers only change on the final bit, so they hold the prior result meanwhile.
        if (last) begin
          sum_d  = acc_shift;
          cout_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
